// File: rtl/execute_mdu_if.sv
// Bundle between the execute stage and the multiply/divide unit.
// The pipeline issues operations and the unit reports completion.
interface execute_mdu_if;
    logic        valid;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        flush;
    logic        mult_ok;
    logic [63:0] result;
    logic        busy;

    modport master (output valid, op, a, b, flush, input mult_ok, result, busy);
    modport slave  (input valid, op, a, b, flush, output mult_ok, result, busy);
endinterface

// File: rtl/execute_mdu.sv
// Multi-cycle RV64M multiply/divide unit: pipelined-latency multiply,
// radix-2 restoring divide (one quotient bit per cycle), one op at a time.
module execute_mdu #(
    parameter int MUL_STAGES = 1
) (
    input  logic          clk,
    input  logic          resetn,
    execute_mdu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [5:0] MUL_LAST = 6'(MUL_STAGES - 1);

    state_t      state_reg, state_next;
    logic [2:0]  op_reg, op_next;          // {word_op, op[1:0]}
    logic [63:0] a_reg, a_next;
    logic [63:0] b_reg, b_next;
    logic [5:0]  cnt_reg, cnt_next;
    logic [63:0] rem_reg, rem_next;
    logic [63:0] quo_reg, quo_next;
    logic [63:0] result_reg, result_next;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    logic         w_op, div_signed, is_rem, a_signed, b_signed;
    logic [127:0] ext_a, ext_b, product;
    logic [63:0]  mul_res;

    assign w_op       = op_reg[2];
    assign div_signed = ~op_reg[0];
    assign is_rem     = op_reg[1];
    assign a_signed   = (op_reg[1:0] == 2'd1) || (op_reg[1:0] == 2'd2);
    assign b_signed   = (op_reg[1:0] == 2'd1);
    assign ext_a      = a_signed ? {{64{a_reg[63]}}, a_reg} : {64'd0, a_reg};
    assign ext_b      = b_signed ? {{64{b_reg[63]}}, b_reg} : {64'd0, b_reg};
    assign product    = ext_a * ext_b;
    assign mul_res    = w_op ? sext32(product[31:0]) :
                        (op_reg[1:0] == 2'd0) ? product[63:0] : product[127:64];

    logic [63:0] div_a, div_b, abs_a, abs_b;
    logic        sign_a, sign_b, div_zero, div_ovf, take_bit;
    logic [64:0] rem_shift;
    logic [63:0] rem_step, quo_step, quo_fix, rem_fix, div_raw, special_raw;
    logic [63:0] div_fin, special_fin;

    assign div_a = w_op ? (div_signed ? sext32(a_reg[31:0]) : {32'd0, a_reg[31:0]}) : a_reg;
    assign div_b = w_op ? (div_signed ? sext32(b_reg[31:0]) : {32'd0, b_reg[31:0]}) : b_reg;
    assign sign_a   = div_signed & div_a[63];
    assign sign_b   = div_signed & div_b[63];
    assign abs_a    = sign_a ? -div_a : div_a;
    assign abs_b    = sign_b ? -div_b : div_b;
    assign div_zero = (div_b == 64'd0);
    assign div_ovf  = div_signed & ~w_op & (a_reg == 64'h8000_0000_0000_0000) & (b_reg == '1);

    // Dividend bits enter MSB first; the remainder needs one guard bit for the compare.
    assign rem_shift = {rem_reg, abs_a[6'd63 - cnt_reg]};
    assign take_bit  = rem_shift >= {1'b0, abs_b};
    assign rem_step  = take_bit ? (rem_shift[63:0] - abs_b) : rem_shift[63:0];
    assign quo_step  = {quo_reg[62:0], take_bit};
    assign quo_fix   = (sign_a ^ sign_b) ? -quo_step : quo_step;
    assign rem_fix   = sign_a ? -rem_step : rem_step;
    assign div_raw   = is_rem ? rem_fix : quo_fix;
    assign special_raw = div_zero ? (is_rem ? div_a : '1) : (is_rem ? 64'd0 : a_reg);
    assign div_fin     = w_op ? sext32(div_raw[31:0]) : div_raw;
    assign special_fin = w_op ? sext32(special_raw[31:0]) : special_raw;

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        cnt_next    = cnt_reg;
        rem_next    = rem_reg;
        quo_next    = quo_reg;
        result_next = result_reg;
        case (state_reg)
            IDLE: begin
                if (bus.valid && !bus.flush) begin
                    op_next    = {bus.op[3], bus.op[1:0]};
                    a_next     = bus.a;
                    b_next     = bus.b;
                    cnt_next   = 6'd0;
                    rem_next   = 64'd0;
                    quo_next   = 64'd0;
                    state_next = bus.op[2] ? DIV : MUL;
                end
            end
            MUL: begin
                if (bus.flush) begin
                    state_next = IDLE;
                end else if (cnt_reg == MUL_LAST) begin
                    result_next = mul_res;
                    state_next  = DONE;
                end else begin
                    cnt_next = cnt_reg + 6'd1;
                end
            end
            DIV: begin
                if (bus.flush) begin
                    state_next = IDLE;
                end else if (cnt_reg == 6'd0 && (div_zero || div_ovf)) begin
                    result_next = special_fin;
                    state_next  = DONE;
                end else begin
                    rem_next = rem_step;
                    quo_next = quo_step;
                    cnt_next = cnt_reg + 6'd1;
                    if (cnt_reg == 6'd63) begin
                        result_next = div_fin;
                        state_next  = DONE;
                    end
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= IDLE;
            op_reg     <= 3'd0;
            a_reg      <= 64'd0;
            b_reg      <= 64'd0;
            cnt_reg    <= 6'd0;
            rem_reg    <= 64'd0;
            quo_reg    <= 64'd0;
            result_reg <= 64'd0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            cnt_reg    <= cnt_next;
            rem_reg    <= rem_next;
            quo_reg    <= quo_next;
            result_reg <= result_next;
        end
    end

    assign bus.mult_ok = (state_reg == DONE);
    assign bus.busy    = (state_reg != IDLE);
    assign bus.result  = result_reg;
endmodule

// File: tb/tb_execute_mdu.sv
// Scoreboard bench for execute_mdu: directed ops push expected results,
// independent monitors pop and compare on every mult_ok pulse.
module tb_execute_mdu;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    execute_mdu_if bus ();
    execute_mdu_if bus2 ();

    execute_mdu #(.MUL_STAGES(1)) dut  (.clk(clk), .resetn(resetn), .bus(bus));
    execute_mdu #(.MUL_STAGES(3)) dut2 (.clk(clk), .resetn(resetn), .bus(bus2));

    typedef struct {
        logic [63:0] res;
        longint      cyc;
    } exp_t;

    exp_t   q1[$];
    exp_t   q2[$];
    longint cycle_cnt = 0;
    int     checks = 0;
    int     passes = 0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cycle_cnt);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (resetn && bus.mult_ok) begin
            if (q1.size() == 0) begin
                chk("spurious_mult_ok", bus.result, 64'hx);
            end else begin
                e = q1.pop_front();
                chk("result", bus.result, e.res);
                chk("latency", 64'(cycle_cnt), 64'(e.cyc));
                $display("op done: result=%h cycle=%0d", bus.result, cycle_cnt);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (resetn && bus2.mult_ok) begin
            if (q2.size() == 0) begin
                chk("spurious_mult_ok_s3", bus2.result, 64'hx);
            end else begin
                e = q2.pop_front();
                chk("result_s3", bus2.result, e.res);
                chk("latency_s3", 64'(cycle_cnt), 64'(e.cyc));
                $display("op done (stages=3): result=%h cycle=%0d", bus2.result, cycle_cnt);
            end
        end
    end

    // Called at the negedge of an IDLE cycle (cycle 0); returns at the next IDLE negedge.
    task automatic issue(input bit u2, input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                         input logic [63:0] r, input int lat);
        exp_t e;
        bit   seen;
        e.res = r;
        e.cyc = cycle_cnt + longint'(lat);
        if (u2) begin
            q2.push_back(e);
            bus2.valid = 1'b1; bus2.op = o; bus2.a = x; bus2.b = y;
        end else begin
            q1.push_back(e);
            bus.valid = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        end
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) chk("busy_cycle1", 64'(u2 ? bus2.busy : bus.busy), 64'd1);
            seen = u2 ? bus2.mult_ok : bus.mult_ok;
            if (seen) chk("busy_in_done", 64'(u2 ? bus2.busy : bus.busy), 64'd1);
        end
        chk("completion_seen", 64'(seen), 64'd1);
        bus.valid  = 1'b0;
        bus2.valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.valid = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.flush = 0;
        bus2.valid = 0; bus2.op = 0; bus2.a = 0; bus2.b = 0; bus2.flush = 0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_mult_ok", 64'(bus.mult_ok), 64'd0);
        chk("reset_result", bus.result, 64'd0);
        chk("reset_busy_s3", 64'(bus2.busy), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        issue(0, 4'd0,  64'hFFFF_FFFF_FFFF_FFFD, 64'd7,                 64'hFFFF_FFFF_FFFF_FFEB, 2);
        issue(0, 4'd3,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 2);
        issue(0, 4'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2);
        issue(0, 4'd2,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                 64'hFFFF_FFFF_FFFF_FFFF, 2);
        issue(0, 4'd1,  64'hFFFF_FFFF_FFFF_FFFE, 64'd3,                 64'hFFFF_FFFF_FFFF_FFFF, 2);
        issue(0, 4'd4,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                 64'hFFFF_FFFF_FFFF_FFFD, 65);
        issue(0, 4'd6,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                 64'hFFFF_FFFF_FFFF_FFFF, 65);
        issue(0, 4'd4,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE,                 64'hFFFF_FFFF_FFFF_FFFD, 65);
        issue(0, 4'd6,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE,                 64'd1, 65);
        issue(0, 4'd5,  64'd100, 64'd7, 64'd14, 65);
        issue(0, 4'd7,  64'd100, 64'd7, 64'd2, 65);
        issue(0, 4'd4,  64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        issue(0, 4'd7,  64'd5,   64'd0, 64'd5, 2);
        issue(0, 4'd4,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2);
        issue(0, 4'd6,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2);
        issue(0, 4'd12, 64'h1_8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 65);
        issue(0, 4'd8,  64'h1_0000_0002, 64'h4000_0000, 64'hFFFF_FFFF_8000_0000, 2);
        issue(0, 4'd9,  64'd3, 64'd5, 64'd15, 2);
        issue(0, 4'd15, 64'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        issue(0, 4'd13, 64'hFFFF_FFF0, 64'h10, 64'h0FFF_FFFF, 65);
        issue(0, 4'd14, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);

        // Flush a divide at cycle 30, then a MUL accepted at cycle 31 finishes at 33.
        bus.valid = 1'b1; bus.op = 4'd4; bus.a = 64'd1000; bus.b = 64'd3;
        repeat (30) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_busy", 64'(bus.busy), 64'd0);
        chk("flush_mult_ok", 64'(bus.mult_ok), 64'd0);
        bus.flush = 1'b0;
        issue(0, 4'd0, 64'd5, 64'd6, 64'd30, 2);

        // Asynchronous reset in the middle of a divide.
        bus.valid = 1'b1; bus.op = 4'd5; bus.a = 64'd1000; bus.b = 64'd7;
        repeat (10) @(negedge clk);
        #2 resetn = 1'b0;
        bus.valid = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        chk("rst_mid_mult_ok", 64'(bus.mult_ok), 64'd0);
        chk("rst_mid_result", bus.result, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (70) @(negedge clk);
        issue(0, 4'd7, 64'd100, 64'd7, 64'd2, 65);

        issue(1, 4'd0, 64'd6, 64'd7, 64'd42, 4);
        issue(1, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 4);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(q1.size() + q2.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
